tx_memory_ctl: RTL and testbench

//  Byte-wide frame buffer between the pixel source and the Ethernet TX packetizer.

---
 rtl/tx_memory_ctl.sv | 99 +++++++++
 tb/tb_tx_memory_ctl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tx_memory_ctl.sv
// Byte-wide frame buffer feeding the Ethernet TX packetizer; tracks segment start/last addresses.
// Optional raw readback path via bramaddr24b is enabled by defining TXMEM_DIRECT_READ_EN.
module tx_memory_ctl #(
  parameter int ADDR_W    = 14,
  parameter int SEG_BYTES = 1000
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic [7:0]  rgb_r,
  input  logic [7:0]  rgb_g,
  input  logic [7:0]  rgb_b,
  input  logic [23:0] vramaddr,
  input  logic [1:0]  vramaddr_c,
  input  logic        data_user,
  input  logic        ena,
  input  logic [7:0]  txid,
  input  logic [15:0] segment_num,
  input  logic [7:0]  redundancy,
  input  logic [12:0] count_for_bram,
  input  logic        count_for_bram_en,
  input  logic [12:0] count_for_bram_b,
  input  logic [23:0] bramaddr24b,
  output logic [23:0] startaddr,
  output logic [23:0] lastaddr,
  output logic [7:0]  doutb
);

  localparam logic [29:0] SEG_MUL  = 30'(SEG_BYTES);
  localparam logic [23:0] SEG_LAST = 24'(SEG_BYTES - 1);

  logic [7:0]        r_mem [2**ADDR_W];
  logic [23:0]       r_startaddr;
  logic [23:0]       r_lastaddr;
  logic [7:0]        r_doutb;

  logic [ADDR_W-1:0] w_wa;
  logic [7:0]        w_wdata;
  logic              w_we;
  logic [23:0]       w_seg_start;
  logic              w_upd;
  logic [12:0]       w_off;
  logic [ADDR_W-1:0] w_ra;

  // 3*vramaddr + component, computed at 26 bits then truncated to the memory width
  assign w_wa = ADDR_W'({1'b0, vramaddr, 1'b0} + {2'b0, vramaddr} + {24'b0, vramaddr_c});
  assign w_we = data_user && (vramaddr_c != 2'd3);

  always_comb begin
    w_wdata = rgb_r;
    case (vramaddr_c)
      2'd1:    w_wdata = rgb_g;
      2'd2:    w_wdata = rgb_b;
      default: w_wdata = rgb_r;
    endcase
  end

  assign w_seg_start = 24'({14'b0, segment_num} * SEG_MUL);
  // Copies with txid>0 (accepted or rejected) leave the addresses alone
  assign w_upd = ena && ((redundancy <= 8'd1) || (txid == 8'd0));

  assign w_off = count_for_bram_en ? count_for_bram : count_for_bram_b;

`ifdef TXMEM_DIRECT_READ_EN
  always_comb begin
    w_ra = ADDR_W'(r_startaddr + {11'b0, w_off});
    if (!ena && !count_for_bram_en)
      w_ra = ADDR_W'(bramaddr24b);
  end
`else
  logic w_unused_direct;
  assign w_unused_direct = ^bramaddr24b;
  assign w_ra = ADDR_W'(r_startaddr + {11'b0, w_off});
`endif

  always_ff @(posedge clk125MHz) begin
    if (w_we)
      r_mem[w_wa] <= w_wdata;
  end

  // Read-first: the registered read sees the byte before a same-cycle write
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      r_startaddr <= 24'd0;
      r_lastaddr  <= SEG_LAST;
      r_doutb     <= 8'd0;
    end else begin
      r_doutb <= r_mem[w_ra];
      if (w_upd) begin
        r_startaddr <= w_seg_start;
        r_lastaddr  <= w_seg_start + SEG_LAST;
      end
    end
  end

  assign startaddr = r_startaddr;
  assign lastaddr  = r_lastaddr;
  assign doutb     = r_doutb;

endmodule

// File: tb/tb_tx_memory_ctl.sv
// Scoreboard bench for tx_memory_ctl: read expectations queued at drive time, popped on output.
module tb_tx_memory_ctl;

  logic        clk125MHz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rgb_r = '0, rgb_g = '0, rgb_b = '0;
  logic [23:0] vramaddr = '0;
  logic [1:0]  vramaddr_c = 2'd3;
  logic        data_user = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  txid = '0;
  logic [15:0] segment_num = '0;
  logic [7:0]  redundancy = '0;
  logic [12:0] count_for_bram = '0;
  logic        count_for_bram_en = 1'b1;
  logic [12:0] count_for_bram_b = '0;
  logic [23:0] bramaddr24b = '0;
  logic [23:0] startaddr, lastaddr;
  logic [7:0]  doutb;

  tx_memory_ctl dut (
    .clk125MHz(clk125MHz), .rst(rst),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .vramaddr(vramaddr), .vramaddr_c(vramaddr_c), .data_user(data_user),
    .ena(ena), .txid(txid), .segment_num(segment_num), .redundancy(redundancy),
    .count_for_bram(count_for_bram), .count_for_bram_en(count_for_bram_en),
    .count_for_bram_b(count_for_bram_b), .bramaddr24b(bramaddr24b),
    .startaddr(startaddr), .lastaddr(lastaddr), .doutb(doutb)
  );

  always #4 clk125MHz = ~clk125MHz;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] m_mem [int];
  logic [23:0] m_start = '0;
  logic [7:0] exp_q [$];
  logic       rd_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model one clock: queue read (pre-write, pre-update), then apply write and segment update
  task automatic tick();
    logic [23:0] ra;
    logic [7:0]  wd;
    logic        do_rd;
    int          wa;
    do_rd = rd_en;
    if (do_rd) begin
      ra = m_start + {11'b0, (count_for_bram_en ? count_for_bram : count_for_bram_b)};
      exp_q.push_back(m_mem.exists(int'(ra[13:0])) ? m_mem[int'(ra[13:0])] : 8'hxx);
    end
    if (data_user && vramaddr_c != 2'd3) begin
      wd = (vramaddr_c == 2'd0) ? rgb_r : (vramaddr_c == 2'd1) ? rgb_g : rgb_b;
      wa = int'((3 * {8'b0, vramaddr} + {30'b0, vramaddr_c}) & 32'h3FFF);
      m_mem[wa] = wd;
    end
    if (ena && (redundancy <= 8'd1 || txid == 8'd0))
      m_start = 24'({16'b0, segment_num} * 32'd1000);
    @(posedge clk125MHz);
    #1;
    if (do_rd) begin
      if (exp_q.size() == 0) chk("queue_empty", 32'd1, 32'd0);
      else chk("doutb", {24'b0, doutb}, {24'b0, exp_q.pop_front()});
    end
  endtask

  task automatic wr(input logic [23:0] va, input logic [1:0] c,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic du);
    vramaddr = va; vramaddr_c = c; rgb_r = r; rgb_g = g; rgb_b = b; data_user = du;
    tick();
    data_user = 1'b0;
  endtask

  task automatic rd(input logic [12:0] off);
    rd_en = 1'b1; count_for_bram_en = 1'b1; count_for_bram = off;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic seg(input logic [15:0] s, input logic [7:0] id, input logic [7:0] red);
    segment_num = s; txid = id; redundancy = red; ena = 1'b1;
    tick();
    ena = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk125MHz);
    #1;
    chk("rst_start", {8'b0, startaddr}, 32'd0);
    chk("rst_last",  {8'b0, lastaddr},  32'd999);
    chk("rst_doutb", {24'b0, doutb},    32'd0);
    rst = 1'b0;
    @(posedge clk125MHz); #1;

    wr(24'd2, 2'd0, 8'h11, 8'h22, 8'h33, 1'b1);
    wr(24'd2, 2'd1, 8'h11, 8'h22, 8'h33, 1'b1);
    wr(24'd2, 2'd2, 8'h11, 8'h22, 8'h33, 1'b1);
    wr(24'd3, 2'd0, 8'h44, 8'h00, 8'h00, 1'b1);  // byte 9
    wr(24'd2, 2'd3, 8'h99, 8'h99, 8'h99, 1'b1);  // component 3: no write
    wr(24'd3, 2'd0, 8'h55, 8'h00, 8'h00, 1'b0);  // strobe low: no write
    wr(24'd1667, 2'd2, 8'h00, 8'h00, 8'h5A, 1'b1); // byte 5003

    seg(16'd0, 8'd0, 8'd1);
    chk("seg0_start", {8'b0, startaddr}, 32'd0);
    chk("seg0_last",  {8'b0, lastaddr},  32'd999);
    rd(13'd6); rd(13'd7); rd(13'd8); rd(13'd9);

    seg(16'd5, 8'd0, 8'd3);
    chk("seg5_start", {8'b0, startaddr}, 32'd5000);
    chk("seg5_last",  {8'b0, lastaddr},  32'd5999);
    rd(13'd3);
    seg(16'd9, 8'd1, 8'd3);
    chk("copy1_start", {8'b0, startaddr}, 32'd5000);
    seg(16'd9, 8'd2, 8'd3);
    chk("copy2_start", {8'b0, startaddr}, 32'd5000);
    seg(16'd9, 8'd3, 8'd3);
    chk("reject_start", {8'b0, startaddr}, 32'd5000);
    chk("reject_last",  {8'b0, lastaddr},  32'd5999);
    seg(16'd9, 8'd5, 8'd1);
    chk("red1_start", {8'b0, startaddr}, 32'd9000);
    chk("red1_last",  {8'b0, lastaddr},  32'd9999);
    seg(16'hFFFF, 8'd7, 8'd0);
    chk("wrap_start", {8'b0, startaddr}, 32'd15203352);
    chk("wrap_last",  {8'b0, lastaddr},  32'd15204351);
    seg(16'd0, 8'd0, 8'd3);
    chk("back0_start", {8'b0, startaddr}, 32'd0);

    rd_en = 1'b1; count_for_bram_en = 1'b0; count_for_bram_b = 13'd7; count_for_bram = 13'd0;
    tick();
    rd_en = 1'b0; count_for_bram_en = 1'b1;

    rd_en = 1'b1; count_for_bram = 13'd6;
    wr(24'd2, 2'd0, 8'hAA, 8'h00, 8'h00, 1'b1);  // collision: old byte returned
    rd_en = 1'b0;
    rd(13'd6);

    rd_en = 1'b1; count_for_bram = 13'd7;
    seg(16'd5, 8'd0, 8'd1);                       // read uses pre-update start
    rd_en = 1'b0;
    chk("ena_rd_start", {8'b0, startaddr}, 32'd5000);
    rd(13'd3);

    rst = 1'b1; #1;
    chk("midrst_start", {8'b0, startaddr}, 32'd0);
    chk("midrst_last",  {8'b0, lastaddr},  32'd999);
    chk("midrst_doutb", {24'b0, doutb},    32'd0);
    m_start = '0;
    @(posedge clk125MHz); #1;
    rst = 1'b0;
    rd(13'd7);
    rd(13'd6);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
